// File: rtl/ps2_command_tx_if.sv
// Host-side handshake for the PS/2 command transmitter: command byte, request, busy and
// the three one-cycle completion pulses.
interface ps2_command_tx_if;
    logic [7:0] the_command;
    logic       send_command;
    logic       busy;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic       error_nack;

    modport master (
        output the_command,
        output send_command,
        input  busy,
        input  command_was_sent,
        input  error_communication_timed_out,
        input  error_nack
    );

    modport slave (
        input  the_command,
        input  send_command,
        output busy,
        output command_was_sent,
        output error_communication_timed_out,
        output error_nack
    );
endinterface

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift data+odd parity, check ACK.
// Optional PS2_TX_RETRY_EN: the first failure silently restarts the whole sequence once.
module ps2_command_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned XFER_TIMEOUT   = 100000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    ps2_command_tx_if.slave  host,
    inout  wire              PS2_CLK,
    inout  wire              PS2_DAT
);

    localparam int unsigned MaxSx    = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT
                                                                      : XFER_TIMEOUT;
    localparam int unsigned TimerMax = (MaxSx > INHIBIT_CYCLES) ? MaxSx : INHIBIT_CYCLES;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);

    localparam logic [TimerW-1:0] InhibitLast = TimerW'(INHIBIT_CYCLES - 1);
    localparam logic [TimerW-1:0] StartLimit  = TimerW'(START_TIMEOUT);
    localparam logic [TimerW-1:0] XferLimit   = TimerW'(XFER_TIMEOUT);

    typedef enum logic [3:0] {
        StIdle,
        StInhibit,
        StRts,
        StRelease,
        StTx,
        StAck,
        StWaitIdle,
        StDone,
        StFail
    } state_e;

    state_e              state_q;
    logic [7:0]          cmd_q;
    logic [TimerW-1:0]   timer_q;
    logic [3:0]          bit_cnt_q;
    logic                clk_oe_q;
    logic                dat_oe_q;
    logic                busy_q;
    logic                sent_q;
    logic                timeout_q;
    logic                nack_q;
    logic                fail_nack_q;
    logic [1:0]          clk_sync_q;
    logic [1:0]          dat_sync_q;
    logic                clk_prev_q;
`ifdef PS2_TX_RETRY_EN
    logic                retried_q;
`endif

    logic              clk_fall;
    logic              parity;
    logic              xfer_expired;
    logic [TimerW-1:0] timer_inc;

    assign clk_fall     = clk_prev_q & ~clk_sync_q[1];
    assign parity       = ~^cmd_q;
    assign xfer_expired = (timer_q == XferLimit);

    // Saturating increment so a stalled bus can never wrap the timer back to zero.
    always_comb begin
        timer_inc = timer_q;
        if (~&timer_q) begin
            timer_inc = timer_q + 1'b1;
        end
    end

    assign PS2_CLK = clk_oe_q ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_oe_q ? 1'b0 : 1'bz;

    assign host.busy                          = busy_q;
    assign host.command_was_sent              = sent_q;
    assign host.error_communication_timed_out = timeout_q;
    assign host.error_nack                    = nack_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_q       <= 8'h00;
            timer_q     <= '0;
            bit_cnt_q   <= 4'd0;
            clk_oe_q    <= 1'b0;
            dat_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            timeout_q   <= 1'b0;
            nack_q      <= 1'b0;
            fail_nack_q <= 1'b0;
            // Idle bus level, so leaving reset never fakes a falling edge.
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            clk_prev_q  <= 1'b1;
`ifdef PS2_TX_RETRY_EN
            retried_q   <= 1'b0;
`endif
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
            clk_prev_q <= clk_sync_q[1];
            sent_q     <= 1'b0;
            timeout_q  <= 1'b0;
            nack_q     <= 1'b0;

            unique case (state_q)
                StIdle: begin
`ifdef PS2_TX_RETRY_EN
                    retried_q <= 1'b0;
`endif
                    if (host.send_command) begin
                        cmd_q    <= host.the_command;
                        busy_q   <= 1'b1;
                        timer_q  <= '0;
                        clk_oe_q <= 1'b1;
                        dat_oe_q <= 1'b0;
                        state_q  <= StInhibit;
                    end
                end

                StInhibit: begin
                    if (timer_q == InhibitLast) begin
                        dat_oe_q <= 1'b1;
                        state_q  <= StRts;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end

                StRts: begin
                    clk_oe_q  <= 1'b0;
                    timer_q   <= '0;
                    bit_cnt_q <= 4'd0;
                    state_q   <= StRelease;
                end

                StRelease: begin
                    // The edge is checked first: an edge in the timeout cycle still counts.
                    if (clk_fall) begin
                        dat_oe_q  <= ~cmd_q[0];
                        bit_cnt_q <= 4'd1;
                        timer_q   <= '0;
                        state_q   <= StTx;
                    end else if (timer_q == StartLimit) begin
                        fail_nack_q <= 1'b0;
                        state_q     <= StFail;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end

                StTx: begin
                    if (clk_fall) begin
                        timer_q   <= timer_inc;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q <= 4'd7) begin
                            dat_oe_q <= ~cmd_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            dat_oe_q <= ~parity;
                        end else begin
                            dat_oe_q <= 1'b0;
                            state_q  <= StAck;
                        end
                    end else if (xfer_expired) begin
                        fail_nack_q <= 1'b0;
                        state_q     <= StFail;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end

                StAck: begin
                    if (clk_fall) begin
                        timer_q <= timer_inc;
                        if (dat_sync_q[1]) begin
                            fail_nack_q <= 1'b1;
                            state_q     <= StFail;
                        end else begin
                            state_q <= StWaitIdle;
                        end
                    end else if (xfer_expired) begin
                        fail_nack_q <= 1'b0;
                        state_q     <= StFail;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end

                StWaitIdle: begin
                    if (clk_sync_q[1] && dat_sync_q[1]) begin
                        state_q <= StDone;
                    end else if (xfer_expired) begin
                        fail_nack_q <= 1'b0;
                        state_q     <= StFail;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end

                StDone: begin
                    sent_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end

                StFail: begin
`ifdef PS2_TX_RETRY_EN
                    if (!retried_q) begin
                        retried_q <= 1'b1;
                        timer_q   <= '0;
                        clk_oe_q  <= 1'b1;
                        dat_oe_q  <= 1'b0;
                        state_q   <= StInhibit;
                    end else begin
                        clk_oe_q  <= 1'b0;
                        dat_oe_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        nack_q    <= fail_nack_q;
                        timeout_q <= ~fail_nack_q;
                        state_q   <= StIdle;
                    end
`else
                    clk_oe_q  <= 1'b0;
                    dat_oe_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    nack_q    <= fail_nack_q;
                    timeout_q <= ~fail_nack_q;
                    state_q   <= StIdle;
`endif
                end

                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Scoreboard bench for ps2_command_tx: stimulus queues expected pulses, a monitor pops and
// compares them; a behavioural keyboard clocks the frame and returns what it received.
module tb_ps2_command_tx;

    localparam int unsigned InhibitCycles = 20;
    localparam int unsigned StartTimeout  = 200;
    localparam int unsigned XferTimeout   = 2000;

    localparam logic [2:0] EvDone    = 3'b001;
    localparam logic [2:0] EvTimeout = 3'b010;
    localparam logic [2:0] EvNack    = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wire  ps2_clk;
    wire  ps2_dat;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    ps2_command_tx_if bus ();

    ps2_command_tx #(
        .INHIBIT_CYCLES(InhibitCycles),
        .START_TIMEOUT (StartTimeout),
        .XFER_TIMEOUT  (XferTimeout)
    ) dut (
        .CLOCK_50(clk),
        .reset   (rst),
        .host    (bus),
        .PS2_CLK (ps2_clk),
        .PS2_DAT (ps2_dat)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    int         dev_bit = 0;
    logic [2:0] exp_q[$];

    initial forever #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest expected event.
    initial begin
        logic [2:0] obs;
        forever begin
            @(negedge clk);
            obs = {bus.error_nack, bus.error_communication_timed_out, bus.command_was_sent};
            if (obs != 3'b000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'(obs), 32'd0);
                end else begin
                    check("pulse_kind", 32'(obs), 32'(exp_q.pop_front()));
                    check("busy_low_at_pulse", 32'(bus.busy), 32'd0);
                end
            end
        end
    end

    // Keyboard model: waits for request-to-send, clocks 10 bits, then one ACK clock.
    task automatic dev_xfer(input bit nack, output logic [7:0] rx, output logic par,
                            output logic stop_b, output bit got_rts);
        int          t = 0;
        logic [9:0]  sh = '0;
        rx = 8'h00; par = 1'b0; stop_b = 1'b0; got_rts = 1'b0; dev_bit = 0;
        while (!(ps2_clk === 1'b0 && ps2_dat === 1'b0) && t < 3000) begin
            @(negedge clk); t++;
        end
        while (ps2_clk === 1'b0 && t < 3000) begin
            @(negedge clk); t++;
        end
        if (t >= 3000) return;
        got_rts = 1'b1;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            sh[i] = ps2_dat;
            dev_bit = i + 1;
            repeat (20) @(negedge clk);
        end
        dev_dat_low = ~nack;
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        rx = sh[7:0]; par = sh[8]; stop_b = sh[9];
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        bus.the_command  = c;
        bus.send_command = 1'b1;
        @(negedge clk);
        bus.send_command = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (bus.busy !== 1'b0 && t < 4000) begin
            @(negedge clk); t++;
        end
        check({name, "_finished_in_budget"}, 32'(t < 4000), 32'd1);
        repeat (5) @(negedge clk);
        check({name, "_pulses_all_seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        logic       par, stp;
        bit         rts, rts2;
        int         lo, t, since, busy_cnt;

        bus.the_command  = 8'h00;
        bus.send_command = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_pulses", 32'({bus.error_nack, bus.error_communication_timed_out,
                                   bus.command_was_sent}), 32'd0);
        check("reset_lines_released", 32'({ps2_clk, ps2_dat}), 32'b11);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: 0xED acknowledged; inhibit phase length and frame contents.
        dev_bit = 0;
        exp_q.push_back(EvDone);
        fork
            dev_xfer(1'b0, rx, par, stp, rts);
            begin
                send(8'hED);
                check("busy_after_accept", 32'(bus.busy), 32'd1);
                lo = 0; t = 0;
                while (ps2_dat === 1'b1 && t < 100) begin
                    if (ps2_clk === 1'b0) lo++;
                    @(negedge clk); t++;
                end
                check("inhibit_cycles", 32'(lo), 32'd20);
            end
        join
        check("ed_rts_seen", 32'(rts), 32'd1);
        check("ed_rx_byte", 32'(rx), 32'hED);
        check("ed_parity", 32'(par), 32'd1);
        check("ed_stop", 32'(stp), 32'd1);
        wait_idle("ed");

        // 2: device never clocks -> start timeout, lines released.
        exp_q.push_back(EvTimeout);
        send(8'hFF);
        since = 0; t = 0;
        while (bus.error_communication_timed_out !== 1'b1 && t < 3000) begin
            @(negedge clk); t++;
            if (ps2_clk === 1'b0) since = 0;
            else since++;
        end
        check("timeout_after_release", 32'(since >= 200 && since <= 205), 32'd1);
        check("timeout_lines_released", 32'({ps2_clk, ps2_dat}), 32'b11);
        wait_idle("timeout");

        // 3: device answers NACK (twice when retry is enabled).
        exp_q.push_back(EvNack);
        fork
            begin
                dev_xfer(1'b1, rx, par, stp, rts);
`ifdef PS2_TX_RETRY_EN
                dev_xfer(1'b1, rx, par, stp, rts);
`endif
            end
            send(8'hF4);
        join
        check("f4_rx_byte", 32'(rx), 32'hF4);
        check("f4_parity", 32'(par), 32'd0);
        wait_idle("nack");

        // 4: a second request during TX is neither applied nor queued.
        dev_bit = 0;
        exp_q.push_back(EvDone);
        fork
            dev_xfer(1'b0, rx, par, stp, rts);
            begin
                send(8'h12);
                t = 0;
                while (dev_bit < 3 && t < 3000) begin
                    @(negedge clk); t++;
                end
                bus.the_command  = 8'h34;
                bus.send_command = 1'b1;
                repeat (3) @(negedge clk);
                bus.send_command = 1'b0;
            end
        join
        check("busy_rx_byte", 32'(rx), 32'h12);
        check("busy_parity", 32'(par), 32'd1);
        wait_idle("busy_ignore");
        busy_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
        end
        check("no_queued_send", 32'(busy_cnt), 32'd0);

        // 5: reset while bit 4 is on the wire, then a clean send.
        dev_bit = 0;
        fork
            dev_xfer(1'b0, rx, par, stp, rts);
            begin
                send(8'h00);
                t = 0;
                while (dev_bit != 4 && t < 3000) begin
                    @(negedge clk); t++;
                end
                rst = 1'b1;
                @(negedge clk);
                check("midreset_dat_released", 32'(ps2_dat), 32'd1);
                check("midreset_clk_released", 32'(ps2_clk), 32'd1);
                check("midreset_busy", 32'(bus.busy), 32'd0);
                rst = 1'b0;
            end
        join
        wait_idle("midreset");
        exp_q.push_back(EvDone);
        fork
            dev_xfer(1'b0, rx, par, stp, rts);
            send(8'hED);
        join
        check("post_reset_rx_byte", 32'(rx), 32'hED);
        wait_idle("post_reset");

`ifdef PS2_TX_RETRY_EN
        // 6: one NACK is absorbed by a full retry.
        exp_q.push_back(EvDone);
        rts2 = 1'b0;
        fork
            begin
                dev_xfer(1'b1, rx, par, stp, rts);
                dev_xfer(1'b0, rx, par, stp, rts2);
            end
            send(8'hAB);
        join
        check("retry_second_rts", 32'(rts2), 32'd1);
        check("retry_rx_byte", 32'(rx), 32'hAB);
        check("retry_parity", 32'(par), 32'd0);
        wait_idle("retry");
`endif

        check("scoreboard_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within budget");
        $fatal(1, "watchdog");
    end

endmodule
